// File: rtl/pc_redirect_ctrl.sv
// Next-PC scheduler: arbitrates trap/branch/jump/sequential sources and replays
// redirects that arrive while a cache stall blocks the PC from moving.
module pc_redirect_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             jump_valid,
    input  logic [XLEN-1:0]  jump_target,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  trap_vector,
    input  logic             load_use_hazard,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic [XLEN-1:0]  new_pc,
    output logic             pc_write,
    output logic             flush,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic {RUN, PEND} state_t;

    // Kind encoding doubles as priority: a larger value wins.
    localparam logic [1:0] K_NONE   = 2'd0;
    localparam logic [1:0] K_JUMP   = 2'd1;
    localparam logic [1:0] K_BRANCH = 2'd2;
    localparam logic [1:0] K_TRAP   = 2'd3;

    state_t            state_reg, state_next;
    logic [1:0]        pend_kind_reg, pend_kind_next;
    logic [XLEN-1:0]   pend_target_reg, pend_target_next;
    logic [CNT_W-1:0]  count_reg;

    logic              stall;
    logic [XLEN-1:0]   seq_pc;
    logic [1:0]        live_kind;
    logic [XLEN-1:0]   live_target;
    logic [1:0]        apply_kind;
    logic [XLEN-1:0]   apply_target;

    assign stall  = icache_stall | dcache_stall;
    assign seq_pc = pc_in + XLEN'(4);

    always_comb begin
        live_kind   = K_NONE;
        live_target = seq_pc;
        if (trap_req) begin
            live_kind   = K_TRAP;
            live_target = {trap_vector[XLEN-1:2], 2'b00};
        end else if (branch_taken) begin
            live_kind   = K_BRANCH;
            live_target = {branch_target[XLEN-1:2], 2'b00};
        end else if (jump_valid) begin
            live_kind   = K_JUMP;
            live_target = {jump_target[XLEN-1:2], 2'b00};
        end
    end

    always_comb begin
        state_next       = state_reg;
        pend_kind_next   = pend_kind_reg;
        pend_target_next = pend_target_reg;
        apply_kind       = K_NONE;
        apply_target     = seq_pc;
        case (state_reg)
            RUN: begin
                if (live_kind != K_NONE) begin
                    if (stall) begin
                        state_next       = PEND;
                        pend_kind_next   = live_kind;
                        pend_target_next = live_target;
                    end else begin
                        apply_kind   = live_kind;
                        apply_target = live_target;
                    end
                end
            end
            PEND: begin
                if (stall) begin
                    // Equal priority replaces the entry so the newest target is kept.
                    if (live_kind != K_NONE && live_kind >= pend_kind_reg) begin
                        pend_kind_next   = live_kind;
                        pend_target_next = live_target;
                    end
                end else begin
                    state_next = RUN;
                    if (live_kind > pend_kind_reg) begin
                        apply_kind   = live_kind;
                        apply_target = live_target;
                    end else begin
                        apply_kind   = pend_kind_reg;
                        apply_target = pend_target_reg;
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= RUN;
            pend_kind_reg   <= K_NONE;
            pend_target_reg <= '0;
            count_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            pend_kind_reg   <= pend_kind_next;
            pend_target_reg <= pend_target_next;
            if (flush && count_reg != {CNT_W{1'b1}})
                count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign flush            = (apply_kind != K_NONE);
    assign new_pc           = flush ? apply_target : seq_pc;
    assign flush_ifid       = flush;
    assign flush_idex       = (apply_kind == K_TRAP) || (apply_kind == K_BRANCH);
    assign pc_write         = ~load_use_hazard;
    assign redirect_pending = (state_reg == PEND);
    assign redirect_count   = count_reg;

endmodule
